// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and load result inputs plus the RegFile write port.
interface wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_dat;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_dat;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] Rd_dat;
    logic [31:0] busy_mask;

    modport master (
        output alu_valid, alu_rd, alu_dat, ld_valid, ld_rd, ld_dat,
        input  alu_ready, ld_ready, rd, wen, Rd_dat, busy_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_dat, ld_valid, ld_rd, ld_dat,
        output alu_ready, ld_ready, rd, wen, Rd_dat, busy_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, loads go through a FIFO with anti-starvation.
// Define WB_BUSY_MASK_EN to build per-register pending-write tracking on busy_mask.
module wb_arbiter #(
    parameter int LD_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(LD_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [4:0]    r_fifo_rd  [LD_DEPTH];
    logic [31:0]   r_fifo_dat [LD_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_wen;
    logic [4:0]    r_rd;
    logic [31:0]   r_dat;

    logic          w_full, w_nonempty, w_force;
    logic          w_alu_win, w_pop, w_push, w_win;
    logic [4:0]    w_win_rd;
    logic [31:0]   w_win_dat;

    assign w_full     = (r_count == CW'(LD_DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_force    = w_nonempty && (r_starve == SW'(STARVE_MAX));
    assign w_alu_win  = bus.alu_valid && !w_force;
    assign w_pop      = !w_alu_win && w_nonempty;
    assign w_push     = bus.ld_valid && !w_full;
    assign w_win      = w_alu_win || w_pop;
    assign w_win_rd   = w_alu_win ? bus.alu_rd  : r_fifo_rd[r_rptr];
    assign w_win_dat  = w_alu_win ? bus.alu_dat : r_fifo_dat[r_rptr];

    assign bus.alu_ready = !w_force;
    assign bus.ld_ready  = !w_full;
    assign bus.rd        = r_rd;
    assign bus.wen       = r_wen;
    assign bus.Rd_dat    = r_dat;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]  <= bus.ld_rd;
            r_fifo_dat[r_wptr] <= bus.ld_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_wen    <= 1'b0;
            r_rd     <= '0;
            r_dat    <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            // The head only accrues losses while it actually waits behind the ALU.
            if (!w_nonempty || w_pop)
                r_starve <= '0;
            else if (w_alu_win && r_starve != SW'(STARVE_MAX))
                r_starve <= r_starve + SW'(1);
            r_wen <= w_win && (w_win_rd != 5'd0);
            if (w_win) begin
                r_rd  <= w_win_rd;
                r_dat <= w_win_dat;
            end
        end
    end

`ifdef WB_BUSY_MASK_EN
    logic [LD_DEPTH-1:0] r_vld, w_vld_nxt;
    logic [31:0]         r_busy, w_busy_nxt;
    logic [4:0]          w_ent_rd;

    // Mask is built from post-edge FIFO and output-register contents.
    always_comb begin
        w_vld_nxt  = r_vld;
        w_busy_nxt = '0;
        w_ent_rd   = '0;
        if (w_pop)  w_vld_nxt[r_rptr] = 1'b0;
        if (w_push) w_vld_nxt[r_wptr] = 1'b1;
        for (int i = 0; i < LD_DEPTH; i++) begin
            w_ent_rd = (w_push && r_wptr == AW'(i)) ? bus.ld_rd : r_fifo_rd[i];
            if (w_vld_nxt[i]) w_busy_nxt[w_ent_rd] = 1'b1;
        end
        if (w_win && w_win_rd != 5'd0) w_busy_nxt[w_win_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_busy <= '0;
        end else begin
            r_vld  <= w_vld_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.busy_mask = r_busy;
`else
    assign bus.busy_mask = 32'h0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if bus();

    wb_arbiter #(.LD_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dat;
    } ent_t;

    ent_t        q[$];
    int          starve;
    logic        m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_dat;
    bit          m_init;
    bit          a_acc, l_acc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = 32'h0;
`ifdef WB_BUSY_MASK_EN
        foreach (q[i]) b[q[i].rd] = 1'b1;
        if (m_wen) b[m_rd] = 1'b1;
        b[0] = 1'b0;
`endif
        return b;
    endfunction

    // One clock: drive at negedge, check handshakes, advance model, check outputs after edge.
    task automatic cyc(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        bit   frc, win, was_empty, popped;
        ent_t w;
        @(negedge clk);
        rst           = r;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_dat   = adat;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_dat    = ldat;
        #1;
        frc   = (q.size() > 0) && (starve == SMAX);
        a_acc = !r && av && !frc;
        l_acc = !r && lv && (q.size() < DEPTH);
        if (m_init && !r) begin
            chk("alu_ready", 32'(bus.alu_ready), 32'(!frc));
            chk("ld_ready",  32'(bus.ld_ready),  32'(q.size() < DEPTH));
        end
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            starve = 0;
            m_wen  = 1'b0;
            m_rd   = '0;
            m_dat  = '0;
            m_init = 1'b1;
        end else if (m_init) begin
            win       = 1'b0;
            popped    = 1'b0;
            was_empty = (q.size() == 0);
            w.rd      = '0;
            w.dat     = '0;
            if (a_acc) begin
                w.rd  = ard;
                w.dat = adat;
                win   = 1'b1;
            end else if (q.size() > 0) begin
                w      = q.pop_front();
                win    = 1'b1;
                popped = 1'b1;
            end
            if (was_empty || popped) starve = 0;
            else if (a_acc && starve < SMAX) starve++;
            if (l_acc) q.push_back('{rd: lrd, dat: ldat});
            m_wen = win && (w.rd != 5'd0);
            if (win) begin
                m_rd  = w.rd;
                m_dat = w.dat;
            end
        end
        if (m_init) begin
            chk("wen",       32'(bus.wen), 32'(m_wen));
            chk("rd",        32'(bus.rd),  32'(m_rd));
            chk("Rd_dat",    bus.Rd_dat,   m_dat);
            chk("busy_mask", bus.busy_mask, model_busy());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        int          sent;
        bit          pa, pl;
        logic [4:0]  ard, lrd;
        logic [31:0] adat, ldat;
        logic        r;

        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_dat = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_dat  = '0;
        m_init = 1'b0; starve = 0; m_wen = 1'b0; m_rd = '0; m_dat = '0;

        // Reset with both sources asserting valid.
        cyc(1'b1, 1'b1, 5'd3, 32'h111, 1'b1, 5'd4, 32'h222);
        cyc(1'b1, 1'b1, 5'd3, 32'h111, 1'b1, 5'd4, 32'h222);

        // ALU stream, including a write to x0.
        cyc(1'b0, 1'b1, 5'd3, 32'd1000, 1'b0, 5'd0, 32'h0);
        cyc(1'b0, 1'b1, 5'd1, 32'd1,    1'b0, 5'd0, 32'h0);
        cyc(1'b0, 1'b1, 5'd0, 32'd5,    1'b0, 5'd0, 32'h0);
        idle(2);

        // Two loads, ALU idle.
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hA5);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hB6);
        idle(4);

        // Starvation: one load against a continuously valid ALU.
        cyc(1'b0, 1'b1, 5'd9, 32'h900, 1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 5'd9, 32'h900, 1'b0, 5'd0, 32'h0);
        idle(2);

        // Fill to full under ALU pressure, then drain while pushing across the wrap.
        sent = 0;
        for (int i = 0; i < 80 && sent < 10; i++) begin
            cyc(1'b0, (i < 10), 5'd2, 32'h200 + 32'(i), 1'b1, 5'(8 + sent), 32'hD000 + 32'(sent));
            if (l_acc) sent++;
        end
        chk("fill_sent", 32'(sent), 32'd10);
        idle(8);

        // Reset while three loads are buffered.
        cyc(1'b0, 1'b1, 5'd20, 32'h2000, 1'b1, 5'd21, 32'h21);
        cyc(1'b0, 1'b1, 5'd20, 32'h2000, 1'b1, 5'd22, 32'h22);
        cyc(1'b0, 1'b1, 5'd20, 32'h2000, 1'b1, 5'd23, 32'h23);
        cyc(1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0);
        idle(4);

        // Random traffic; a source holds its payload until it transfers.
        pa = 1'b0; pl = 1'b0;
        ard = '0; adat = '0; lrd = '0; ldat = '0;
        for (int i = 0; i < 800; i++) begin
            if (!pa && ($urandom_range(99) < ((i < 400) ? 90 : 45))) begin
                pa = 1'b1; ard = 5'($urandom); adat = $urandom;
            end
            if (!pl && ($urandom_range(99) < 60)) begin
                pl = 1'b1; lrd = 5'($urandom); ldat = $urandom;
            end
            r = ($urandom_range(149) == 0);
            cyc(r, pa, ard, adat, pl, lrd, ldat);
            if (r || a_acc) pa = 1'b0;
            if (r || l_acc) pl = 1'b0;
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the RegFile write port (rd, wen, Rd_dat).
- Merges two result sources into the single write port: single-cycle ALU results and variable-latency load returns from the LSU.
- Load returns are buffered in a small FIFO. ALU results have priority, and an anti-starvation counter guarantees the loads progress.
- All RegFile write outputs are registered.

Parameters:
- LD_DEPTH, 4: load FIFO entries; power of two, minimum 2.
- STARVE_MAX, 3: consecutive cycles the FIFO head may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- alu_rd  in  5  ALU destination register
- alu_dat  in  32  ALU result
- ld_valid  in  1  load data present
- ld_ready  out  1  load accepted this cycle; equals !fifo_full (registered state)
- ld_rd  in  5  load destination register
- ld_dat  in  32  load data
- rd  out  5  to RegFile rd
- wen  out  1  to RegFile wen
- Rd_dat  out  32  to RegFile Rd_dat
- busy_mask  out  32  bit i set while a write to xi is buffered or in flight (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge):
  - rd=0, wen=0, Rd_dat=0.
  - FIFO emptied; count=0, rd/wr pointers=0.
  - starve_cnt=0, busy_mask=0.
  - ld_ready=1 after reset.
  - Reset mid-operation discards all buffered loads; no write is issued for them.
- Handshakes:
  - Transfer on valid&ready at the rising edge.
  - A source may drop valid only after its transfer.
  - Both inputs may transfer in the same cycle.
- Load path:
  - An accepted load is pushed into the FIFO; it never bypasses the FIFO.
  - Minimum latency: accept at edge N, write to FIFO head; earliest wen=1 in the cycle after edge N+1.
- Arbitration, evaluated each cycle; at most one winner:
  - force = fifo_nonempty && (starve_cnt == STARVE_MAX).
  - alu_ready = !force.
  - If alu_valid && alu_ready: the ALU wins.
  - Else if fifo_nonempty: the FIFO head wins and is popped.
  - Else: no write.
- Starvation counter:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Clears when the head pops, or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- Output register:
  - At the edge: rd / Rd_dat take the winner's values, and wen = winner exists && winner rd != 0.
  - A write to x0 is accepted and consumed but produces wen=0.
  - rd and Rd_dat are still loaded with the winner's values in that case.
  - With no winner, wen=0 and rd / Rd_dat hold their values.
  - ALU latency: accept at edge N, wen=1 during the following cycle, and the RegFile writes at edge N+1.
- FIFO boundaries:
  - Full: ld_ready=0. Push and pop in the same cycle are legal whenever not full.
  - Pointers wrap modulo LD_DEPTH.
  - count tracks pushes minus pops exactly, including push+pop in the same cycle.
- Ordering:
  - Two loads retire in arrival order.
  - Ordering between ALU and load writes to the same rd is not enforced here. The issue stage must stall on busy_mask.

Optional Feature:
- Macro: WB_BUSY_MASK_EN.
- Defined:
  - busy_mask[i] = 1 if any valid FIFO entry has rd==i, or if the output register holds wen=1 with rd==i.
  - busy_mask[0] is always 0.
  - busy_mask is registered, updated from next-state values so it matches the FIFO and output-register contents after each edge.
- Undefined:
  - busy_mask is tied to 32'h0 and no tracking logic is built.
  - The issue stage must then serialize loads.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 2 cycles with alu_valid=1 and ld_valid=1.
  - Response: wen=0, rd=0, Rd_dat=0, ld_ready=1, busy_mask=0.
  - After releasing rst, the first ALU write appears exactly 1 cycle after acceptance.
- ALU-only stream:
  - Stimulus: alu (rd=3, dat=1000), then (rd=1, dat=1) on consecutive cycles.
  - Response: wen=1 on consecutive cycles with rd=3/Rd_dat=1000, then rd=1/Rd_dat=1.
  - ALU result alu_rd=0, dat=5: accepted (alu_ready=1) and produces wen=0.
- Load latency and ordering:
  - Stimulus: loads (rd=5, dat=0xA5), (rd=6, dat=0xB6), ALU idle.
  - Response: writes appear 2 cycles after each acceptance, in order 5 then 6.
  - With WB_BUSY_MASK_EN: busy_mask bits 5 and 6 set while pending, cleared after their writes leave the output register.
- Starvation:
  - Stimulus: push 1 load (rd=7, dat=0x77), keep alu_valid=1 continuously.
  - Response: ALU wins 3 cycles; on the 4th cycle alu_ready=0, and the load writes rd=7/Rd_dat=0x77.
  - The ALU resumes the next cycle.
- FIFO full / wrap:
  - Stimulus: with alu_valid=1 and STARVE_MAX raised so the ALU keeps winning, push 4 loads.
  - Response: ld_ready=0 at count=4.
  - Then drop alu_valid and push 6 more loads while draining: all 10 writes occur in order with correct data across the pointer wrap.
- Reset mid-operation:
  - Stimulus: 3 loads buffered, then assert rst for 1 cycle.
  - Response: no write for the discarded loads; wen=0 and busy_mask=0 immediately after the reset edge.
